// File: rtl/catapult_softreg_responder.sv
// Soft-register responder: small host-visible register file with a
// 2-entry read-response FIFO, ID/scratch/ctrl/status and two counters.
module catapult_softreg_responder #(
    parameter int SOFTREG_ADDR_WIDTH = 32,
    parameter int SOFTREG_DATA_WIDTH = 64,
    parameter logic [SOFTREG_DATA_WIDTH-1:0] ID_VALUE = 64'h0000_CA7A_0000_0001
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_softreg_req_valid,
    output logic                          io_softreg_req_ready,
    input  logic [SOFTREG_ADDR_WIDTH-1:0] io_softreg_req_bits_addr,
    input  logic [SOFTREG_DATA_WIDTH-1:0] io_softreg_req_bits_wdata,
    input  logic                          io_softreg_req_bits_wr,
    output logic                          io_softreg_resp_valid,
    input  logic                          io_softreg_resp_ready,
    output logic [SOFTREG_DATA_WIDTH-1:0] io_softreg_resp_bits_rdata,
    output logic [SOFTREG_DATA_WIDTH-1:0] ctrl_out,
    input  logic [SOFTREG_DATA_WIDTH-1:0] status_in
);
    localparam int AW = SOFTREG_ADDR_WIDTH;
    localparam int DW = SOFTREG_DATA_WIDTH;

    logic [1:0]    count_q, count_d;
    logic          head_q;
    logic [DW-1:0] fifo_q [2];
    logic [DW-1:0] scratch_q, ctrl_q, cyc_q, reqcnt_q;

    logic          accept, push, pop, wr_acc;
    logic          wr_ptr;
    logic [DW-1:0] rd_data;

    // Ready is forced low while in reset; count_q is cleared asynchronously.
    assign io_softreg_req_ready       = reset && (count_q != 2'd2);
    assign io_softreg_resp_valid      = (count_q != 2'd0);
    assign io_softreg_resp_bits_rdata = io_softreg_resp_valid ? fifo_q[head_q] : '0;
    assign ctrl_out                   = ctrl_q;

    assign accept = io_softreg_req_valid && io_softreg_req_ready;
    assign wr_acc = accept && io_softreg_req_bits_wr;
    assign push   = accept && !io_softreg_req_bits_wr;
    assign pop    = io_softreg_resp_valid && io_softreg_resp_ready;
    assign wr_ptr = head_q ^ count_q[0];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_comb begin
        rd_data = '1;
        case (io_softreg_req_bits_addr)
            AW'(0):  rd_data = ID_VALUE;
            AW'(1):  rd_data = scratch_q;
            AW'(2):  rd_data = ctrl_q;
            AW'(3):  rd_data = status_in;
            AW'(4):  rd_data = cyc_q;
            AW'(5):  rd_data = reqcnt_q;
            default: rd_data = '1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            head_q    <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            count_q <= count_d;
            if (pop) begin
                head_q <= ~head_q;
            end
            if (push) begin
                fifo_q[wr_ptr] <= rd_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scratch_q <= '0;
            ctrl_q    <= '0;
            cyc_q     <= '0;
            reqcnt_q  <= '0;
        end else begin
            if (wr_acc && io_softreg_req_bits_addr == AW'(1)) begin
                scratch_q <= io_softreg_req_bits_wdata;
            end
            if (wr_acc && io_softreg_req_bits_addr == AW'(2)) begin
                ctrl_q <= io_softreg_req_bits_wdata;
            end
            if (wr_acc && io_softreg_req_bits_addr == AW'(4)) begin
                cyc_q <= '0;
            end else begin
                cyc_q <= cyc_q + DW'(1);
            end
            if (accept) begin
                reqcnt_q <= reqcnt_q + DW'(1);
            end
        end
    end
endmodule

// File: tb/tb_catapult_softreg_responder.sv
// Directed bench for catapult_softreg_responder: vector table plus
// hand-written FIFO back-pressure, counter and mid-transaction reset sequences.
module tb_catapult_softreg_responder;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam logic [DW-1:0] ID = 64'h0000_CA7A_0000_0001;
    localparam logic [DW-1:0] ONES = '1;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_ready;
    logic [DW-1:0] resp_rdata, ctrl_out, status_in;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    catapult_softreg_responder dut (
        .clock                      (clock),
        .reset                      (reset),
        .io_softreg_req_valid       (req_valid),
        .io_softreg_req_ready       (req_ready),
        .io_softreg_req_bits_addr   (req_addr),
        .io_softreg_req_bits_wdata  (req_wdata),
        .io_softreg_req_bits_wr     (req_wr),
        .io_softreg_resp_valid      (resp_valid),
        .io_softreg_resp_ready      (resp_ready),
        .io_softreg_resp_bits_rdata (resp_rdata),
        .ctrl_out                   (ctrl_out),
        .status_in                  (status_in)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] status;
        logic          exp_valid;
        logic [DW-1:0] exp_rdata;
        logic [DW-1:0] exp_ctrl;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = v;
        req_wr    = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        // {wr, addr, wdata, status, exp_valid, exp_rdata, exp_ctrl}
        vecs[0]  = '{1'b0, 32'd0, 64'd0, 64'd0, 1'b1, ID, 64'd0};
        vecs[1]  = '{1'b1, 32'd2, 64'h1234, 64'd0, 1'b0, 64'd0, 64'h1234};
        vecs[2]  = '{1'b0, 32'd2, 64'd0, 64'd0, 1'b1, 64'h1234, 64'h1234};
        vecs[3]  = '{1'b1, 32'd1, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 1'b0,
                     64'd0, 64'h1234};
        vecs[4]  = '{1'b0, 32'd1, 64'd0, 64'd0, 1'b1,
                     64'hDEAD_BEEF_CAFE_F00D, 64'h1234};
        vecs[5]  = '{1'b0, 32'd3, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b1,
                     64'h0123_4567_89AB_CDEF, 64'h1234};
        vecs[6]  = '{1'b0, 32'd7, 64'd0, 64'd0, 1'b1, ONES, 64'h1234};
        vecs[7]  = '{1'b1, 32'd0, 64'hFF, 64'd0, 1'b0, 64'd0, 64'h1234};
        vecs[8]  = '{1'b0, 32'd0, 64'd0, 64'd0, 1'b1, ID, 64'h1234};
        vecs[9]  = '{1'b1, 32'd5, 64'h55, 64'd0, 1'b0, 64'd0, 64'h1234};
        vecs[10] = '{1'b0, 32'd5, 64'd0, 64'd0, 1'b1, 64'd10, 64'h1234};
        vecs[11] = '{1'b1, 32'd3, 64'h77, 64'h5A5A, 1'b0, 64'd0, 64'h1234};
        vecs[12] = '{1'b0, 32'd3, 64'd0, 64'h5A5A, 1'b1, 64'h5A5A, 64'h1234};
        vecs[13] = '{1'b0, 32'd6, 64'd0, 64'd0, 1'b1, ONES, 64'h1234};
        vecs[14] = '{1'b0, 32'h8000_0002, 64'd0, 64'd0, 1'b1, ONES, 64'h1234};

        reset      = 1'b0;
        resp_ready = 1'b1;
        status_in  = '0;
        drive(1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clock);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_ctrl_out", ctrl_out, 64'd0);
        reset = 1'b1;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            drive(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            status_in = vecs[i].status;
            chk($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'd1);
            @(negedge clock);
            drive(1'b0, 1'b0, '0, '0);
            status_in = ~vecs[i].status;
            chk($sformatf("v%0d_resp_valid", i), 64'(resp_valid),
                64'(vecs[i].exp_valid));
            if (!vecs[i].wr) begin
                chk($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
            end
            chk($sformatf("v%0d_ctrl_out", i), ctrl_out, vecs[i].exp_ctrl);
            @(negedge clock);
            chk($sformatf("v%0d_resp_done", i), 64'(resp_valid), 64'd0);
        end

        // Cycle counter clear followed by back-to-back reads of it
        @(negedge clock);
        drive(1'b1, 1'b1, 32'd4, 64'hABCD);
        @(negedge clock);
        drive(1'b0, 1'b0, '0, '0);
        chk("cyc_wr_noresp", 64'(resp_valid), 64'd0);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'd4, '0);
        @(negedge clock);
        chk("cyc_rd1", resp_rdata, 64'd1);
        @(negedge clock);
        drive(1'b0, 1'b0, '0, '0);
        chk("cyc_rd2_valid", 64'(resp_valid), 64'd1);
        chk("cyc_rd2", resp_rdata, 64'd2);
        @(negedge clock);
        chk("cyc_done", 64'(resp_valid), 64'd0);

        // Fill the FIFO, then reset with responses queued
        resp_ready = 1'b0;
        drive(1'b1, 1'b0, 32'd0, '0);
        @(negedge clock);
        @(negedge clock);
        drive(1'b0, 1'b0, '0, '0);
        chk("full_ready", 64'(req_ready), 64'd0);
        chk("full_valid", 64'(resp_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 64'(resp_valid), 64'd0);
        chk("async_rst_ready", 64'(req_ready), 64'd0);
        chk("async_rst_rdata", resp_rdata, 64'd0);
        repeat (2) @(negedge clock);
        chk("async_rst_ctrl", ctrl_out, 64'd0);

        // Release and run three reads of the request counter under back-pressure
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'd5, '0);
        #1;
        chk("rel_ready", 64'(req_ready), 64'd1);
        chk("rel_empty", 64'(resp_valid), 64'd0);
        @(negedge clock);
        chk("bp_ready_after1", 64'(req_ready), 64'd1);
        @(negedge clock);
        chk("bp_ready_after2", 64'(req_ready), 64'd0);
        chk("bp_head0", resp_rdata, 64'd0);
        @(negedge clock);
        chk("bp_hold_valid", 64'(resp_valid), 64'd1);
        chk("bp_hold_rdata", resp_rdata, 64'd0);
        chk("bp_hold_ready", 64'(req_ready), 64'd0);
        resp_ready = 1'b1;
        @(negedge clock);
        chk("bp_ready_after_pop", 64'(req_ready), 64'd1);
        chk("bp_head1", resp_rdata, 64'd1);
        @(negedge clock);
        drive(1'b0, 1'b0, '0, '0);
        chk("bp_third_valid", 64'(resp_valid), 64'd1);
        chk("bp_head2", resp_rdata, 64'd2);
        @(negedge clock);
        chk("bp_drained", 64'(resp_valid), 64'd0);

        // Counters since release: 6 edges elapsed, 3 requests so far
        drive(1'b1, 1'b0, 32'd4, '0);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'd5, '0);
        chk("cyc_since_rel", resp_rdata, 64'd6);
        @(negedge clock);
        drive(1'b0, 1'b0, '0, '0);
        chk("reqcnt_since_rel", resp_rdata, 64'd4);
        @(negedge clock);
        chk("final_empty", 64'(resp_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
